// File: rtl/pa_risc_pkg.sv
// Shared PA-RISC front-end definitions: sequencer state encoding, address width
// and reset defaults, instruction size.
package pa_risc_pkg;

  localparam int          DEFAULT_PC_W     = 32;
  localparam int          INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    NULL = 2'd2
  } state_e;

endpackage

// File: rtl/nullify_logic.sv
// Delay-slot nullify decision for a resolving branch. Unconditional branches
// nullify on N alone; conditional ones on forward-taken or backward-not-taken.
module nullify_logic (
  input  logic uncond,
  input  logic n_bit,
  input  logic j,
  input  logic backward,
  output logic nullify
);

  assign nullify = uncond ? n_bit
                          : (n_bit & ((j & ~backward) | (~j & backward)));

endmodule

// File: rtl/pc_sequencer.sv
// IAOQ front/back sequencer with delayed-branch redirect and delay-slot nullify.
// Optional macro PC_SEQ_PERF_COUNTERS_EN adds saturating TAKEN_CNT / NULL_CNT.
module pc_sequencer
  import pa_risc_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            STALL,
  input  logic            BR_VALID,
  input  logic            J,
  input  logic [PC_W-1:0] TA,
  input  logic            N_BIT,
  input  logic            BACKWARD,
  input  logic            UNCOND,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] NPC,
  output logic            FETCH_VALID,
  output logic            NULLIFY
`ifdef PC_SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]     TAKEN_CNT,
  output logic [31:0]     NULL_CNT
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            br_nullify;
  logic            advance;
  logic            taken;

  nullify_logic u_nullify_logic (
    .uncond   (UNCOND),
    .n_bit    (N_BIT),
    .j        (J),
    .backward (BACKWARD),
    .nullify  (br_nullify)
  );

  // BOOT swallows its single unstalled edge, so a branch there never redirects.
  assign advance = ~STALL & (state_q != BOOT);
  assign taken   = advance & BR_VALID & J;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    if (!STALL) begin
      if (state_q == BOOT) begin
        state_d = RUN;
      end else begin
        pc_d    = npc_q;
        npc_d   = taken ? {TA[PC_W-1:2], 2'b00} : npc_q + PC_W'(INSN_BYTES);
        state_d = (BR_VALID && br_nullify) ? NULL : RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + PC_W'(INSN_BYTES);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

  assign PC          = pc_q;
  assign NPC         = npc_q;
  assign FETCH_VALID = (state_q != BOOT);
  assign NULLIFY     = (state_q == NULL);

`ifdef PC_SEQ_PERF_COUNTERS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] null_cnt_q;
  logic        null_entry;

  assign null_entry = advance & (state_d == NULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q <= '0;
      null_cnt_q  <= '0;
    end else begin
      if (taken && (taken_cnt_q != 32'hFFFF_FFFF))
        taken_cnt_q <= taken_cnt_q + 32'd1;
      if (null_entry && (null_cnt_q != 32'hFFFF_FFFF))
        null_cnt_q <= null_cnt_q + 32'd1;
    end
  end

  assign TAKEN_CNT = taken_cnt_q;
  assign NULL_CNT  = null_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// boot/reset sequences, then random stimulus against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        STALL, BR_VALID, J, N_BIT, BACKWARD, UNCOND;
  logic [31:0] TA;
  logic [31:0] PC, NPC;
  logic        FETCH_VALID, NULLIFY;
`ifdef PC_SEQ_PERF_COUNTERS_EN
  logic [31:0] TAKEN_CNT, NULL_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .STALL       (STALL),
    .BR_VALID    (BR_VALID),
    .J           (J),
    .TA          (TA),
    .N_BIT       (N_BIT),
    .BACKWARD    (BACKWARD),
    .UNCOND      (UNCOND),
    .PC          (PC),
    .NPC         (NPC),
    .FETCH_VALID (FETCH_VALID),
    .NULLIFY     (NULLIFY)
`ifdef PC_SEQ_PERF_COUNTERS_EN
    ,
    .TAKEN_CNT   (TAKEN_CNT),
    .NULL_CNT    (NULL_CNT)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        stall, br, j, n, back, unc;
    logic [31:0] ta;
    logic [31:0] pc, npc;
    logic        fv, nul;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic stall, br, j, n, back, unc, input logic [31:0] ta);
    STALL = stall; BR_VALID = br; J = j; N_BIT = n; BACKWARD = back; UNCOND = unc; TA = ta;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, npc, input logic fv, nul);
    check({tag, ".pc"}, PC, pc);
    check({tag, ".npc"}, NPC, npc);
    check({tag, ".fv"}, {31'd0, FETCH_VALID}, {31'd0, fv});
    check({tag, ".nul"}, {31'd0, NULLIFY}, {31'd0, nul});
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
  endtask

  // Behavioural model: architectural queue plus two flags.
  logic [31:0] m_pc, m_npc;
  bit          m_boot, m_null;
  longint      m_taken, m_nulls;

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h4; m_boot = 1; m_null = 0; m_taken = 0; m_nulls = 0;
  endtask

  task automatic model_edge(input logic stall, br, j, n, back, unc, input logic [31:0] ta);
    bit kill;
    if (stall) return;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    kill = br && n && (unc ? 1'b1 : (j != back));
    m_pc  = m_npc;
    m_npc = (br && j) ? (ta & 32'hFFFF_FFFC) : m_npc + 32'd4;
    m_null = kill;
    if (br && j) m_taken++;
    if (kill) m_nulls++;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #12;

    // ---- directed table ----
    //            stall br j n back unc  ta            pc            npc           fv nul
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h4,        1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h4,        32'h8,        1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h8,        32'hC,        1, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 32'h100,       32'hC,        32'h100,      1, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h100,      32'h104,      1, 0};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 32'h200,       32'h104,      32'h200,      1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h200,      32'h204,      1, 0};
    vecs[7]  = '{0, 1, 1, 1, 0, 0, 32'h300,       32'h204,      32'h300,      1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h300,      32'h304,      1, 0};
    vecs[9]  = '{0, 1, 0, 1, 1, 0, 32'h50,        32'h304,      32'h308,      1, 1};
    vecs[10] = '{0, 1, 1, 1, 1, 0, 32'h80,        32'h308,      32'h80,       1, 0};
    vecs[11] = '{0, 1, 1, 1, 0, 1, 32'h40,        32'h80,       32'h40,       1, 1};
    vecs[12] = '{0, 1, 1, 1, 0, 0, 32'h13,        32'h40,       32'h10,       1, 1};
    vecs[13] = '{1, 1, 1, 1, 0, 0, 32'h500,       32'h40,       32'h10,       1, 1};
    vecs[14] = '{1, 1, 1, 1, 0, 0, 32'h500,       32'h40,       32'h10,       1, 1};
    vecs[15] = '{1, 1, 1, 1, 0, 0, 32'h500,       32'h40,       32'h10,       1, 1};
    vecs[16] = '{0, 1, 1, 1, 0, 0, 32'h500,       32'h10,       32'h500,      1, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h500,      32'h504,      1, 0};
    vecs[18] = '{0, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h504,      32'hFFFF_FFFC, 1, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,       1, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h4,        1, 0};
    vecs[21] = '{0, 0, 1, 1, 0, 0, 32'h900,       32'h4,        32'h8,        1, 0};

    @(posedge clk); #1;
    reset = 1'b0;
    check_all("reset", 32'h0, 32'h4, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].j, vecs[i].n, vecs[i].back, vecs[i].unc, vecs[i].ta);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].npc, vecs[i].fv, vecs[i].nul);
    end

    // ---- stall in BOOT holds, then a branch presented in BOOT is ignored ----
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    step();
    check_all("boot_stall", 32'h0, 32'h4, 1'b0, 1'b0);
    drive(0, 1, 1, 1, 0, 1, 32'h700);
    step();
    check_all("boot_branch", 32'h0, 32'h4, 1'b1, 1'b0);

    // ---- asynchronous reset while in NULL ----
    drive(0, 1, 1, 1, 0, 1, 32'h80);
    step();
    check_all("pre_rst_null", 32'h4, 32'h80, 1'b1, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h4, 1'b0, 1'b0);
    #1 reset = 1'b0;
    step();
    check_all("post_rst", 32'h0, 32'h4, 1'b1, 1'b0);

    // ---- random stimulus against the model ----
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic s, b, jj, nn, bk, u;
      logic [31:0] t;
      s  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 2) != 0);
      jj = $urandom_range(0, 1);
      nn = $urandom_range(0, 1);
      bk = $urandom_range(0, 1);
      u  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      drive(s, b, jj, nn, bk, u, t);
      step();
      model_edge(s, b, jj, nn, bk, u, t);
      check_all($sformatf("rnd%0d", i), m_pc, m_npc, !m_boot, m_null);
`ifdef PC_SEQ_PERF_COUNTERS_EN
      check($sformatf("rnd%0d.taken_cnt", i), TAKEN_CNT, 32'(m_taken));
      check($sformatf("rnd%0d.null_cnt", i), NULL_CNT, 32'(m_nulls));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Downstream consumer of the condition handler's jump decision J.
- Holds the two-entry PA-RISC instruction address queue: PC (front, IAOQ_F) and NPC (back, IAOQ_B).
- Applies delayed-branch redirection and generates the delay-slot NULLIFY pulse from J, the branch nullify bit and the branch direction.
- Sits between the branch-resolve stage and the fetch stage.

Parameters:
- PC_W, 32, address width.
- RESET_PC, 32'h0000_0000, PC value after reset; NPC resets to RESET_PC+4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- STALL  in  1  hold all state when 1.
- BR_VALID  in  1  a branch is resolving this cycle; J, TA, N_BIT, BACKWARD and UNCOND are valid.
- J  in  1  branch taken, from the condition handler.
- TA  in  PC_W  branch target address.
- N_BIT  in  1  nullify bit of the branch instruction.
- BACKWARD  in  1  branch displacement is negative.
- UNCOND  in  1  branch is unconditional (BL class).
- PC  out  PC_W  current fetch address (IAOQ_F).
- NPC  out  PC_W  next address (IAOQ_B).
- FETCH_VALID  out  1  PC is a real fetch; 0 during BOOT.
- NULLIFY  out  1  squash the delay-slot instruction now leaving fetch.

Behaviour:
- Reset (asynchronous, any time, including mid-branch or during STALL):
  - PC=RESET_PC, NPC=RESET_PC+4, FETCH_VALID=0, NULLIFY=0.
  - State=BOOT; any pending nullify is discarded.
- States: BOOT, RUN, NULL.
  - BOOT: lasts exactly one unstalled cycle, then goes to RUN with FETCH_VALID=1. PC/NPC do not advance on the BOOT exit edge.
  - RUN: normal sequencing.
  - NULL: NULLIFY=1. Next unstalled edge goes to RUN, or back to NULL if a new nullifying branch resolves on that edge.
- Advance, on an unstalled edge in RUN or NULL:
  - PC <= NPC.
  - NPC <= TA if (BR_VALID & J), else NPC+4.
  - The instruction at old NPC is the delay slot and always issues (delayed branch).
  - Arithmetic is modulo 2^PC_W; wrap from 32'hFFFF_FFFC to 0 is legal. TA[1:0] is forced to 00.
- Nullify decision, evaluated only when BR_VALID and the edge is unstalled:
  - UNCOND: nullify = N_BIT.
  - Conditional: nullify = N_BIT & ((J & ~BACKWARD) | (~J & BACKWARD)).
  - If nullify, next state is NULL; otherwise RUN.
- NULLIFY is registered: asserted for exactly one unstalled cycle, covering the delay-slot instruction.
- STALL=1: PC, NPC, state and NULLIFY hold. BR_VALID is ignored because the stage holds the branch and re-presents it.
- BR_VALID asserted in BOOT is ignored.
- Latency: J to NPC update, 1 edge. J to NULLIFY, 1 edge.
- J with BR_VALID=0 is ignored.

Optional Feature:
- Macro: PC_SEQ_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs TAKEN_CNT[31:0] and NULL_CNT[31:0], both reset to 0.
  - TAKEN_CNT increments on each unstalled BR_VALID&J edge.
  - NULL_CNT increments on each entry to NULL.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pa_risc_pkg: state enum {BOOT, RUN, NULL}, PC_W, INSN_BYTES=4, RESET_PC default.
- One natural sub-module: nullify_logic, a combinational nullify decision from UNCOND, N_BIT, J and BACKWARD; reused by any later trap/interrupt redirect logic.

Test Plan:
- Reset then 3 unstalled cycles, no branches -> PC=0,0,4,8; FETCH_VALID 0,1,1,1; NULLIFY stays 0.
- PC=0x100, NPC=0x104, BR_VALID=1, J=1, TA=0x200, N_BIT=0 -> PC=0x104, NPC=0x200, NULLIFY=0; then PC=0x200, NPC=0x204.
- Forward taken with N_BIT=1, BACKWARD=0, J=1 -> NULLIFY=1 for exactly one cycle. Repeat with BACKWARD=1, J=0 -> NULLIFY=1. BACKWARD=1, J=1 -> NULLIFY=0.
- UNCOND=1, N_BIT=1, TA=0x40 -> NPC=0x40, NULLIFY=1.
- BR_VALID with STALL=1 held for 3 cycles, then released -> PC/NPC/NULLIFY unchanged for 3 cycles; redirect happens on the release edge only.
- NPC=0xFFFF_FFFC advance -> NPC=0x0000_0000. Assert reset in NULL state -> NULLIFY=0, PC=RESET_PC immediately, without waiting for a clock edge.
